mc_sequencer: RTL and testbench

- Main control sequencer for the multicycle ARM datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Owns the NZCV status register and condition evaluation.
- Drives every datapath mux select, write enable and the 4-bit ALUControl.
- Replaces the single-cycle controller; the datapath shares one memory port and holds the IR (instruction register), so Instr is stable from the cycle after FETCH until the next FETCH.

---
 rtl/mc_sequencer_if.sv | 31 +++
 rtl/mc_sequencer.sv | 157 +++++++++++++++
 tb/tb_mc_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if: instruction fields, ALU flags and datapath controls between sequencer and datapath.
interface mc_sequencer_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic [3:0] StatusRegister;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [3:0] ALUControl;
    logic [3:0] state_dbg;
    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output StatusRegister, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, state_dbg
    );
    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  StatusRegister, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, state_dbg
    );
endinterface

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle ARM control FSM with NZCV register, condition check and datapath control.
module mc_sequencer #(
    parameter logic [3:0] FLAG_RESET = 4'h0
) (
    input logic          clk,
    input logic          reset,
    mc_sequencer_if.slave bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;

    logic [3:0] state_q, state_d;
    logic [3:0] nzcv_q, nzcv_d;
    logic       cond_pass_q, cond_pass_d;
    logic       cond_ok;
    logic       n, z, c, v;
    logic [3:0] cmd;
    logic       is_cmp, is_arith, is_exec;
    logic [3:0] alu_dec;
    logic       reg_we, mem_we, pc_we, ir_we;

    assign {n, z, c, v} = nzcv_q;
    assign cmd      = bus.Funct[4:1];
    assign is_cmp   = cmd == 4'b1010;
    assign is_arith = cmd == 4'b0100 || cmd == 4'b0010 || is_cmp;
    assign is_exec  = state_q == EXECUTER || state_q == EXECUTEI;
    assign alu_dec  = cmd == 4'b0010 ? 4'h1 :
                      cmd == 4'b0000 ? 4'h2 :
                      cmd == 4'b1100 ? 4'h3 :
                      is_cmp         ? 4'h1 : 4'h0;

    always_comb begin
        case (bus.Cond)
            4'b0000: cond_ok = z;
            4'b0001: cond_ok = !z;
            4'b0010: cond_ok = c;
            4'b0011: cond_ok = !c;
            4'b0100: cond_ok = n;
            4'b0101: cond_ok = !n;
            4'b0110: cond_ok = v;
            4'b0111: cond_ok = !v;
            4'b1000: cond_ok = c && !z;
            4'b1001: cond_ok = !c || z;
            4'b1010: cond_ok = n == v;
            4'b1011: cond_ok = n != v;
            4'b1100: cond_ok = !z && (n == v);
            4'b1101: cond_ok = z || (n != v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            nzcv_q      <= FLAG_RESET;
            cond_pass_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            nzcv_q      <= nzcv_d;
            cond_pass_q <= cond_pass_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE:   state_d = bus.Op == 2'b01 ? MEMADR :
                                bus.Op == 2'b10 ? BRANCH :
                                bus.Op == 2'b11 ? FETCH  :
                                bus.Funct[5]    ? EXECUTEI : EXECUTER;
            MEMADR:   state_d = bus.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Flags commit only on the edge leaving an executed, flag-setting instruction.
    always_comb begin
        cond_pass_d = state_q == DECODE ? cond_ok : cond_pass_q;
        nzcv_d      = nzcv_q;
        if (is_exec && cond_pass_q && (bus.Funct[0] || is_cmp))
            nzcv_d = {bus.ALUFlags[3:2], is_arith ? bus.ALUFlags[1:0] : nzcv_q[1:0]};
    end

    always_comb begin
        pc_we          = 1'b0;
        ir_we          = 1'b0;
        reg_we         = 1'b0;
        mem_we         = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = 4'h0;
        case (state_q)
            FETCH: begin
                ir_we         = 1'b1;
                pc_we         = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            MEMADR:   bus.ALUSrcB = 2'b01;
            MEMREAD:  bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_we        = cond_pass_q;
                pc_we         = cond_pass_q && bus.Rd == 4'd15;
            end
            MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mem_we     = cond_pass_q;
            end
            EXECUTER: bus.ALUControl = alu_dec;
            EXECUTEI: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_dec;
            end
            ALUWB: begin
                reg_we = cond_pass_q && !is_cmp;
                pc_we  = cond_pass_q && !is_cmp && bus.Rd == 4'd15;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                pc_we         = cond_pass_q;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite        = pc_we && !reset;
    assign bus.IRWrite        = ir_we && !reset;
    assign bus.RegWrite       = reg_we && !reset;
    assign bus.MemWrite       = mem_we && !reset;
    assign bus.StatusRegister = nzcv_q;
    assign bus.ImmSrc         = bus.Op;
    assign bus.RegSrc         = {bus.Op == 2'b10, bus.Op == 2'b01};
    assign bus.state_dbg      = state_q;
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed instruction sequences with hand-computed control and flag expectations.
module tb_mc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    mc_sequencer_if bus ();
    mc_sequencer #(.FLAG_RESET(4'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic stp;
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] cnd, input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
        bus.Cond  = cnd;
        bus.Op    = op;
        bus.Funct = fn;
        bus.Rd    = rd;
    endtask

    task automatic wr_zero(input string tag);
        chk({tag, "_pc"}, 8'(bus.PCWrite), 8'd0);
        chk({tag, "_ir"}, 8'(bus.IRWrite), 8'd0);
        chk({tag, "_rw"}, 8'(bus.RegWrite), 8'd0);
        chk({tag, "_mw"}, 8'(bus.MemWrite), 8'd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.ALUFlags = 4'h0;
        instr(4'hE, 2'b11, 6'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst_state", 8'(bus.state_dbg), 8'd0);
        chk("rst_flags", 8'(bus.StatusRegister), 8'h0);
        wr_zero("rst");
        reset = 1'b0;
        #1;
        chk("post_rst_ir", 8'(bus.IRWrite), 8'd1);
        chk("post_rst_pc", 8'(bus.PCWrite), 8'd1);
        // ADDS register form, AL
        instr(4'hE, 2'b00, 6'b001001, 4'd1);
        stp; chk("adds_dec", 8'(bus.state_dbg), 8'd1);
        chk("dec_pc", 8'(bus.PCWrite), 8'd0);
        stp; chk("adds_exr", 8'(bus.state_dbg), 8'd6);
        chk("adds_alu", 8'(bus.ALUControl), 8'h0);
        chk("adds_srcb", 8'(bus.ALUSrcB), 8'd0);
        bus.ALUFlags = 4'b0110;
        stp; chk("adds_wb", 8'(bus.state_dbg), 8'd8);
        chk("adds_rw", 8'(bus.RegWrite), 8'd1);
        chk("adds_flags", 8'(bus.StatusRegister), 8'b0110);
        stp; chk("adds_fetch", 8'(bus.state_dbg), 8'd0);
        // BNE with Z=1: not taken
        instr(4'b0001, 2'b10, 6'd0, 4'd0);
        stp; stp; chk("bne_z1_st", 8'(bus.state_dbg), 8'd9);
        chk("bne_z1_pc", 8'(bus.PCWrite), 8'd0);
        chk("bne_regsrc", 8'(bus.RegSrc), 8'b10);
        stp;
        // ADDS clearing flags
        instr(4'hE, 2'b00, 6'b001001, 4'd2);
        stp; stp; bus.ALUFlags = 4'b0000;
        stp; chk("adds0_flags", 8'(bus.StatusRegister), 8'h0);
        stp;
        instr(4'b0001, 2'b10, 6'd0, 4'd0);
        stp; stp; chk("bne_z0_pc", 8'(bus.PCWrite), 8'd1);
        stp;
        // LDR to R15
        instr(4'hE, 2'b01, 6'b011001, 4'd15);
        stp; chk("ldr_dec", 8'(bus.state_dbg), 8'd1);
        stp; chk("ldr_adr", 8'(bus.state_dbg), 8'd2);
        chk("ldr_srcb", 8'(bus.ALUSrcB), 8'b01);
        stp; chk("ldr_rd", 8'(bus.state_dbg), 8'd3);
        chk("ldr_adrsrc", 8'(bus.AdrSrc), 8'd1);
        stp; chk("ldr_wb", 8'(bus.state_dbg), 8'd4);
        chk("ldr_res", 8'(bus.ResultSrc), 8'b01);
        chk("ldr_rw", 8'(bus.RegWrite), 8'd1);
        chk("ldr_pc", 8'(bus.PCWrite), 8'd1);
        stp; chk("ldr_fetch", 8'(bus.state_dbg), 8'd0);
        // STR EQ with Z=0: suppressed, then reset in MEMWRITE
        instr(4'b0000, 2'b01, 6'b011000, 4'd3);
        stp; stp; stp; chk("str_st", 8'(bus.state_dbg), 8'd5);
        chk("str_mw", 8'(bus.MemWrite), 8'd0);
        chk("str_adrsrc", 8'(bus.AdrSrc), 8'd1);
        reset = 1'b1;
        #1; chk("midrst_state", 8'(bus.state_dbg), 8'd0);
        wr_zero("midrst");
        stp; wr_zero("midrst2");
        reset = 1'b0;
        #1; chk("rel_ir", 8'(bus.IRWrite), 8'd1);
        chk("rel_pc", 8'(bus.PCWrite), 8'd1);
        // CMP: flags update, no register write
        instr(4'hE, 2'b00, 6'b010101, 4'd4);
        stp; stp; chk("cmp_alu", 8'(bus.ALUControl), 8'h1);
        bus.ALUFlags = 4'b0100;
        stp; chk("cmp_rw", 8'(bus.RegWrite), 8'd0);
        chk("cmp_flags", 8'(bus.StatusRegister), 8'b0100);
        stp;
        // ORRS: N,Z load, C,V hold at 0
        instr(4'hE, 2'b00, 6'b011001, 4'd5);
        stp; stp; chk("orr_alu", 8'(bus.ALUControl), 8'h3);
        bus.ALUFlags = 4'b1011;
        stp; chk("orr_flags", 8'(bus.StatusRegister), 8'b1000);
        stp;
        // SUBS immediate: EXECUTEI
        instr(4'hE, 2'b00, 6'b100101, 4'd6);
        stp; stp; chk("subi_st", 8'(bus.state_dbg), 8'd7);
        chk("subi_alu", 8'(bus.ALUControl), 8'h1);
        chk("subi_srcb", 8'(bus.ALUSrcB), 8'b01);
        bus.ALUFlags = 4'b0011;
        stp; chk("subi_flags", 8'(bus.StatusRegister), 8'b0011);
        stp;
        // ANDS: C,V hold at 1
        instr(4'hE, 2'b00, 6'b000001, 4'd7);
        stp; stp; chk("and_alu", 8'(bus.ALUControl), 8'h2);
        bus.ALUFlags = 4'b1100;
        stp; chk("and_flags", 8'(bus.StatusRegister), 8'b1111);
        stp;
        // ADD without S leaves flags
        instr(4'hE, 2'b00, 6'b001000, 4'd8);
        stp; stp; bus.ALUFlags = 4'b0000;
        stp; chk("add_noS_flags", 8'(bus.StatusRegister), 8'b1111);
        stp;
        // Op=11: DECODE back to FETCH, no writes
        instr(4'hE, 2'b11, 6'd0, 4'd0);
        stp; chk("nop_dec", 8'(bus.state_dbg), 8'd1);
        chk("nop_rw", 8'(bus.RegWrite), 8'd0);
        stp; chk("nop_fetch", 8'(bus.state_dbg), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end
endmodule
